// File: rtl/fifo_word_reader.sv
// Purpose : packs BEATS consecutive FIFO entries into one wide word; a flush closes a partial word with a keep mask.
// Latency : word_valid_o rises the cycle after the edge that pops the last beat (or accepts the flush).
// Backpr. : while a word is held and word_ready_i is low, no pops are issued, so the FIFO absorbs the stall.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   fifo_data_i/_empty_i     head entry and empty flag of the upstream FIFO
//   fifo_pop_o               pop request; the head is consumed on the same rising edge
//   flush_i                  close the current partial word at the next opportunity
//   word_o/keep_o            assembled word (beat 0 in the low bits) and per-beat valid mask
//   word_valid_o/ready_i     output handshake
//   words_o                  wrapping count of delivered words

module fifo_word_reader #(
    parameter int DATAW = 8,
    parameter int BEATS = 4,
    parameter int CNTW  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [DATAW-1:0]       fifo_data_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_pop_o,
    input  logic                   flush_i,
    output logic [DATAW*BEATS-1:0] word_o,
    output logic [BEATS-1:0]       keep_o,
    output logic                   word_valid_o,
    input  logic                   word_ready_i,
    output logic [CNTW-1:0]        words_o
);

    localparam int WW = DATAW * BEATS;
    localparam int CW = $clog2(BEATS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WW-1:0]    acc_q;
    logic [BEATS-1:0] keep_q;
    logic [CNTW-1:0]  words_q;

    logic pop;
    logic last_beat;

    // A held word can only be replaced on the very edge it is accepted, so in
    // HOLD a pop is allowed only together with word_ready_i. Gating with rst_ni
    // keeps the FIFO untouched for the whole reset period.
    assign pop       = rst_ni && !fifo_empty_i &&
                       ((state_q == COLLECT) || word_ready_i);
    assign last_beat = (cnt_q == CW'(BEATS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            acc_q   <= '0;
            keep_q  <= '0;
            words_q <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (pop) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (cnt_q == CW'(i)) begin
                                acc_q[i*DATAW +: DATAW] <= fifo_data_i;
                                keep_q[i]               <= 1'b1;
                            end
                        end
                        // A flush on a popping cycle still includes the popped beat.
                        if (last_beat || flush_i) begin
                            state_q <= HOLD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end else if (flush_i && (cnt_q != '0)) begin
                        // Flush with nothing collected is dropped: never emit an empty word.
                        state_q <= HOLD;
                        cnt_q   <= '0;
                    end
                end

                HOLD: begin
                    // word_valid_o is high in HOLD, so ready alone completes the handshake.
                    if (word_ready_i) begin
                        words_q <= words_q + CNTW'(1);
                        state_q <= COLLECT;
                        if (pop) begin
                            // Back-to-back: the next word starts in slot 0 on the same edge.
                            acc_q  <= WW'(fifo_data_i);
                            keep_q <= BEATS'(1);
                            cnt_q  <= CW'(1);
                        end else begin
                            acc_q  <= '0;
                            keep_q <= '0;
                            cnt_q  <= '0;
                        end
                    end
                end

                default: state_q <= COLLECT;
            endcase
        end
    end

    assign fifo_pop_o   = pop;
    assign word_o       = acc_q;
    assign keep_o       = keep_q;
    assign word_valid_o = (state_q == HOLD);
    assign words_o      = words_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Purpose : exercises fifo_word_reader (DATAW=8, BEATS=4, CNTW=4) against a beat-list reference model.
// Latency : expected words are queued when the model closes a word; a monitor compares on every negedge.
// Backpr. : word_ready_i is driven low in directed and random phases to hold words.

module tb_fifo_word_reader;

    localparam int DW = 8;
    localparam int NB = 4;
    localparam int CW = 4;

    logic            clk_i        = 1'b0;
    logic            rst_ni       = 1'b0;
    logic [DW-1:0]   fifo_data_i  = '0;
    logic            fifo_empty_i = 1'b1;
    logic            fifo_pop_o;
    logic            flush_i      = 1'b0;
    logic [DW*NB-1:0] word_o;
    logic [NB-1:0]   keep_o;
    logic            word_valid_o;
    logic            word_ready_i = 1'b0;
    logic [CW-1:0]   words_o;

    fifo_word_reader #(.DATAW(DW), .BEATS(NB), .CNTW(CW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_pop_o   (fifo_pop_o),
        .flush_i      (flush_i),
        .word_o       (word_o),
        .keep_o       (keep_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .words_o      (words_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state (owned by the driver)
    logic [7:0]  fifo_q[$];
    logic [7:0]  pend_q[$];
    logic [31:0] exp_word_q[$];
    logic [3:0]  exp_keep_q[$];
    bit          holding  = 1'b0;
    bit          exp_pop  = 1'b0;
    bit          done     = 1'b0;
    int          words_exp = 0;

    // Scoreboard bookkeeping (owned by the monitor)
    int rd_idx = 0;
    int errors = 0;
    int checks = 0;

    task automatic close_word();
        logic [31:0] w;
        logic [3:0]  k;
        w = '0;
        k = '0;
        for (int i = 0; i < pend_q.size(); i++) begin
            w[i*8 +: 8] = pend_q[i];
            k[i]        = 1'b1;
        end
        exp_word_q.push_back(w);
        exp_keep_q.push_back(k);
        pend_q.delete();
        holding = 1'b1;
    endtask

    // One clock: apply inputs, predict the pop, then advance the model past the edge.
    task automatic tick(input bit rdy, input bit fl);
        logic [7:0] head;
        word_ready_i = rdy;
        flush_i      = fl;
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? 8'hEE : fifo_q[0];
        exp_pop      = !fifo_empty_i && (!holding || rdy);
        head         = fifo_data_i;
        @(posedge clk_i);
        if (holding) begin
            if (rdy) begin
                holding = 1'b0;
                words_exp++;
                pend_q.delete();
                if (exp_pop) pend_q.push_back(head);
            end
        end else begin
            if (exp_pop) pend_q.push_back(head);
            if (pend_q.size() == NB || (fl && pend_q.size() > 0)) close_word();
        end
        if (exp_pop) void'(fifo_q.pop_front());
        #1;
    endtask

    // Asserted between clock edges so the monitor can see the asynchronous effect.
    task automatic reset_pulse();
        #2;
        rst_ni    = 1'b0;
        holding   = 1'b0;
        exp_pop   = 1'b0;
        words_exp = 0;
        pend_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    // Driver / stimulus
    initial begin
        // 1: four beats waiting at reset release
        fifo_q.push_back(8'h11);
        fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33);
        fifo_q.push_back(8'h44);
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (6) tick(1'b1, 1'b0);

        // 2: backpressure with a non-empty FIFO, then release
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h50 + i));
        repeat (10) tick(1'b0, 1'b0);
        repeat (8) tick(1'b1, 1'b0);

        // 3: partial flush, then a flush with nothing collected
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0);
        repeat (2) tick(1'b1, 1'b1);
        repeat (2) tick(1'b1, 1'b0);

        // 4: flush on the same cycle as the pop of beat 2
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        fifo_q.push_back(8'hCC);
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b0);

        // 5a: reset with two beats collected
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h60 + i));
        repeat (2) tick(1'b1, 1'b0);
        reset_pulse();
        for (int i = 0; i < 2; i++) fifo_q.push_back(8'(8'h70 + i));
        repeat (6) tick(1'b1, 1'b0);

        // 5b: reset while a word is held
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h80 + i));
        repeat (6) tick(1'b0, 1'b0);
        reset_pulse();
        for (int i = 0; i < 2; i++) fifo_q.push_back(8'(8'h90 + i));
        repeat (8) tick(1'b1, 1'b0);

        // 6: 17 back-to-back words wrap the 4-bit counter to 1
        reset_pulse();
        fifo_q.delete();
        for (int i = 0; i < 68; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
        repeat (72) tick(1'b1, 1'b0);

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) != 0) fifo_q.push_back(8'($urandom_range(0, 255)));
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        // Drain everything still pending
        repeat (40) tick(1'b1, 1'b1);
        done = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    initial begin
        while (!done) begin
            @(negedge clk_i or negedge rst_ni);
            if (done) break;
            if (!rst_ni) begin
                #1;
                rd_idx = exp_word_q.size();
                check("rst_word",  word_o,       32'h0);
                check("rst_keep",  keep_o,       32'h0);
                check("rst_valid", word_valid_o, 32'h0);
                check("rst_words", words_o,      32'h0);
                check("rst_pop",   fifo_pop_o,   32'h0);
            end else begin
                check("valid",     word_valid_o, holding);
                check("pop",       fifo_pop_o,   exp_pop);
                check("pop_empty", fifo_pop_o & fifo_empty_i, 32'h0);
                check("words",     words_o,      32'(words_exp & 15));
                if (word_valid_o) begin
                    check("keep_nonzero", keep_o != '0, 32'h1);
                    if (rd_idx < exp_word_q.size()) begin
                        check("word", word_o, exp_word_q[rd_idx]);
                        check("keep", keep_o, exp_keep_q[rd_idx]);
                    end else begin
                        check("word_unexpected", word_valid_o, 32'h0);
                    end
                    if (word_ready_i) rd_idx++;
                end
            end
        end
        check("all_delivered", rd_idx, exp_word_q.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
